alu_issue_stage: RTL and testbench

- Decode/issue pipeline register that drives the ALU's A, B and 4-bit mode inputs. It is the producing end of the ALU operand/mode interface.
- Takes a fetched RV32I instruction plus register-file read data and PC, decodes the ALU operation and operand sources, and registers the result into a single-entry ID/EX stage.
- Uses valid/ready handshakes on both sides, with a flush input for branch/jump redirects.

---
 rtl/alu_issue_stage_if.sv | 35 +++
 rtl/alu_issue_stage.sv | 165 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bundle: upstream instruction handshake plus the registered ALU operand/mode outputs.
interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_mode;
  logic            is_branch;
  logic            jump;
  logic [XLEN-1:0] store_data;
  logic            illegal;
  logic [XLEN-1:0] out_pc;

  // master = the issue stage (producer of ALU operands), slave = its environment
  modport master (
    input  in_valid, in_instr, in_pc, in_rs1, in_rs2, flush, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_mode, is_branch, jump,
           store_data, illegal, out_pc
  );

  modport slave (
    output in_valid, in_instr, in_pc, in_rs1, in_rs2, flush, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_mode, is_branch, jump,
           store_data, illegal, out_pc
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue register: decodes ALU mode and operand sources into a single ID/EX entry
// with valid/ready on both sides and a highest-priority flush.
module alu_issue_stage #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_issue_stage_if.master   bus
);
  localparam logic [3:0] M_ADD = 4'b0000, M_SUB = 4'b0001, M_AND = 4'b0010, M_OR  = 4'b0011;
  localparam logic [3:0] M_XOR = 4'b0100, M_SLL = 4'b0101, M_SRL = 4'b0110, M_SRA = 4'b0111;
  localparam logic [3:0] M_LTU = 4'b1000, M_GEU = 4'b1001, M_NE  = 4'b1011, M_LT  = 4'b1100;
  localparam logic [3:0] M_GE  = 4'b1101;

  localparam logic [6:0] OPC_OP   = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011, OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111;

  // Shared funct3 table for OP and OP-IMM; alt selects sub (000) or sra (101).
  function automatic logic [3:0] f3_mode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? M_SUB : M_ADD;
      3'b001:  return M_SLL;
      3'b010:  return M_LT;
      3'b011:  return M_LTU;
      3'b100:  return M_XOR;
      3'b101:  return alt ? M_SRA : M_SRL;
      3'b110:  return M_OR;
      default: return M_AND;
    endcase
  endfunction

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_u;
  logic [XLEN-1:0] w_a, w_b, w_sd;
  logic [3:0]      w_mode;
  logic            w_br, w_jmp, w_ill, w_shift;
  logic            w_accept;

  assign w_opcode = bus.in_instr[6:0];
  assign w_f3     = bus.in_instr[14:12];
  assign w_f7     = bus.in_instr[31:25];
  assign w_imm_i  = XLEN'($signed(bus.in_instr[31:20]));
  assign w_imm_s  = XLEN'($signed({bus.in_instr[31:25], bus.in_instr[11:7]}));
  assign w_imm_u  = XLEN'($signed({bus.in_instr[31:12], 12'b0}));
  assign w_shift  = (w_f3 == 3'b001) || (w_f3 == 3'b101);

  always_comb begin
    w_a    = '0;
    w_b    = '0;
    w_sd   = '0;
    w_mode = M_ADD;
    w_br   = 1'b0;
    w_jmp  = 1'b0;
    w_ill  = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_a    = bus.in_rs1;
        w_b    = w_shift ? XLEN'(bus.in_rs2[4:0]) : bus.in_rs2;
        w_mode = f3_mode(w_f3, bus.in_instr[30]);
        w_ill  = !((w_f7 == 7'h00) ||
                   ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
      end
      OPC_OPIMM: begin
        w_a    = bus.in_rs1;
        w_b    = w_shift ? XLEN'(bus.in_instr[24:20]) : w_imm_i;
        w_mode = f3_mode(w_f3, (w_f3 == 3'b101) && bus.in_instr[30]);
        w_ill  = ((w_f3 == 3'b001) && (w_f7 != 7'h00)) ||
                 ((w_f3 == 3'b101) && (w_f7 != 7'h00) && (w_f7 != 7'h20));
      end
      OPC_LOAD: begin
        w_a = bus.in_rs1;
        w_b = w_imm_i;
      end
      OPC_STORE: begin
        w_a  = bus.in_rs1;
        w_b  = w_imm_s;
        w_sd = bus.in_rs2;
      end
      OPC_BRANCH: begin
        w_a  = bus.in_rs1;
        w_b  = bus.in_rs2;
        w_br = 1'b1;
        case (w_f3)
          3'b000:  w_mode = M_SUB;
          3'b001:  w_mode = M_NE;
          3'b100:  w_mode = M_LT;
          3'b101:  w_mode = M_GE;
          3'b110:  w_mode = M_LTU;
          3'b111:  w_mode = M_GEU;
          default: w_ill  = 1'b1;
        endcase
      end
      OPC_LUI:   w_b = w_imm_u;
      OPC_AUIPC: begin
        w_a = bus.in_pc;
        w_b = w_imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        w_a   = bus.in_pc;
        w_b   = XLEN'(4);
        w_jmp = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal entries still travel to EX, but with neutral operands and no control effects.
    if (w_ill) begin
      w_a    = '0;
      w_b    = '0;
      w_sd   = '0;
      w_mode = M_ADD;
      w_br   = 1'b0;
      w_jmp  = 1'b0;
    end
  end

  logic            r_valid;
  logic [XLEN-1:0] r_a, r_b, r_sd, r_pc;
  logic [3:0]      r_mode;
  logic            r_br, r_jmp, r_ill;

  assign bus.in_ready = !r_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sd    <= '0;
      r_pc    <= RESET_PC_TAG;
      r_mode  <= M_ADD;
      r_br    <= 1'b0;
      r_jmp   <= 1'b0;
      r_ill   <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_a     <= w_a;
      r_b     <= w_b;
      r_sd    <= w_sd;
      r_pc    <= bus.in_pc;
      r_mode  <= w_mode;
      r_br    <= w_br;
      r_jmp   <= w_jmp;
      r_ill   <= w_ill;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_valid  = r_valid;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.alu_mode   = r_mode;
  assign bus.is_branch  = r_br;
  assign bus.jump       = r_jmp;
  assign bus.store_data = r_sd;
  assign bus.illegal    = r_ill;
  assign bus.out_pc     = r_pc;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: mnemonic-level reference model compared every cycle, plus literal pins.
module tb_alu_issue_stage;
  localparam int          XLEN = 32;
  localparam logic [31:0] TAG  = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.XLEN(XLEN)) bus ();
  alu_issue_stage #(.XLEN(XLEN), .RESET_PC_TAG(TAG)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0] a, b, sd, pc;
    logic [3:0]  mode;
    logic        br, jmp, ill;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;
  ent_t m_ent;
  logic m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what each RV32I instruction class must present to EX.
  function automatic ent_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] rs2);
    ent_t        e;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [3:0]  arith [8];
    logic [3:0]  brm [8];
    arith = '{4'h0, 4'h5, 4'hC, 4'h8, 4'h4, 4'h6, 4'h3, 4'h2};
    brm   = '{4'h1, 4'hB, 4'hF, 4'hF, 4'hC, 4'hD, 4'h8, 4'h9};
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    e = '0;
    e.pc = pc;
    if (op == 7'h33) begin
      e.a = rs1;
      e.b = (f3 == 1 || f3 == 5) ? (rs2 & 32'h1F) : rs2;
      e.mode = arith[f3];
      if (f7 == 7'h20 && f3 == 0) e.mode = 4'h1;
      else if (f7 == 7'h20 && f3 == 5) e.mode = 4'h7;
      else if (f7 != 7'h00) e.ill = 1;
    end else if (op == 7'h13) begin
      e.a = rs1;
      e.b = (f3 == 1 || f3 == 5) ? (imm_i & 32'h1F) : imm_i;
      e.mode = arith[f3];
      if (f3 == 5 && f7 == 7'h20) e.mode = 4'h7;
      if (f3 == 1 && f7 != 0) e.ill = 1;
      if (f3 == 5 && f7 != 0 && f7 != 7'h20) e.ill = 1;
    end else if (op == 7'h03) begin
      e.a = rs1; e.b = imm_i;
    end else if (op == 7'h23) begin
      e.a = rs1; e.b = {{20{ins[31]}}, ins[31:25], ins[11:7]}; e.sd = rs2;
    end else if (op == 7'h63) begin
      e.a = rs1; e.b = rs2; e.br = 1; e.mode = brm[f3];
      if (f3 == 2 || f3 == 3) e.ill = 1;
    end else if (op == 7'h37) begin
      e.b = ins & 32'hFFFF_F000;
    end else if (op == 7'h17) begin
      e.a = pc; e.b = ins & 32'hFFFF_F000;
    end else if (op == 7'h6F || op == 7'h67) begin
      e.a = pc; e.b = 4; e.jmp = 1;
    end else begin
      e.ill = 1;
    end
    if (e.ill) begin
      e = '0;
      e.pc = pc;
      e.ill = 1;
    end
    return e;
  endfunction

  function automatic ent_t reset_ent();
    ent_t e;
    e = '0;
    e.pc = TAG;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_ent   <= reset_ent();
    end else if (bus.flush) begin
      m_valid <= 1'b0;
    end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
      m_valid <= 1'b1;
      m_ent   <= model(bus.in_instr, bus.in_pc, bus.in_rs1, bus.in_rs2);
    end else if (bus.out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
      chk("alu_a", bus.alu_a, m_ent.a);
      chk("alu_b", bus.alu_b, m_ent.b);
      chk("alu_mode", 32'(bus.alu_mode), 32'(m_ent.mode));
      chk("is_branch", 32'(bus.is_branch), 32'(m_ent.br));
      chk("jump", 32'(bus.jump), 32'(m_ent.jmp));
      chk("illegal", 32'(bus.illegal), 32'(m_ent.ill));
      chk("store_data", bus.store_data, m_ent.sd);
      chk("out_pc", bus.out_pc, m_ent.pc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic fl, input logic ordy);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.flush     = fl;
    bus.out_ready = ordy;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2);
    drive(1'b1, ins, pc, rs1, rs2, 1'b0, 1'b1);
    $display("txn instr=%h pc=%h rs1=%h rs2=%h", ins, pc, rs1, rs2);
    step();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst out_pc", bus.out_pc, TAG);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    step();

    send(32'h40B50533, 32'h40, 32'd7, 32'd9);
    chk("sub mode", 32'(bus.alu_mode), 32'h1);
    chk("sub a", bus.alu_a, 32'd7);
    chk("sub b", bus.alu_b, 32'd9);
    chk("sub valid", 32'(bus.out_valid), 32'd1);

    send(32'h40335293, 32'h44, 32'h8000_0000, 32'h0);
    chk("srai mode", 32'(bus.alu_mode), 32'h7);
    chk("srai b", bus.alu_b, 32'd3);

    send(32'h00B56463, 32'h48, 32'd1, 32'd2);
    chk("bltu mode", 32'(bus.alu_mode), 32'h8);
    chk("bltu br", 32'(bus.is_branch), 32'd1);

    send(32'hFFFF_FFFF, 32'h4C, 32'd5, 32'd6);
    chk("ill flag", 32'(bus.illegal), 32'd1);
    chk("ill a", bus.alu_a, 32'd0);
    chk("ill b", bus.alu_b, 32'd0);

    send(32'h12345037, 32'h50, 32'd5, 32'd6);
    chk("lui a", bus.alu_a, 32'd0);
    chk("lui b", bus.alu_b, 32'h1234_5000);

    send(32'h0000006F, 32'h100, 32'd5, 32'd6);
    chk("jal a", bus.alu_a, 32'h100);
    chk("jal b", bus.alu_b, 32'd4);
    chk("jal jump", 32'(bus.jump), 32'd1);

    send(32'h00B52423, 32'h104, 32'h2000, 32'hCAFE_F00D);
    chk("sw b", bus.alu_b, 32'd8);
    chk("sw data", bus.store_data, 32'hCAFE_F00D);

    send(32'hFFF10093, 32'h108, 32'd3, 32'd0);
    chk("addi b", bus.alu_b, 32'hFFFF_FFFF);

    send(32'h00001017, 32'h200, 32'd0, 32'd0);
    chk("auipc a", bus.alu_a, 32'h200);
    chk("auipc b", bus.alu_b, 32'h1000);

    send(32'h02000033, 32'h204, 32'd1, 32'd1);
    chk("mul ill", 32'(bus.illegal), 32'd1);
    send(32'h40001013, 32'h208, 32'd1, 32'd1);
    chk("slli ill", 32'(bus.illegal), 32'd1);
    send(32'h00B50063, 32'h20C, 32'd4, 32'd4);
    chk("beq mode", 32'(bus.alu_mode), 32'h1);
    send(32'h40B55533, 32'h210, 32'h55, 32'h23);
    chk("sra b", bus.alu_b, 32'd3);

    // back-pressure: sra entry held for three cycles while add waits
    drive(1'b1, 32'h00B50533, 32'h214, 32'd100, 32'd23, 1'b0, 1'b0);
    $display("txn stall instr=%h", 32'h00B50533);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall a", bus.alu_a, 32'h55);
    end
    bus.out_ready = 1'b1;
    #1 chk("unstall in_ready", 32'(bus.in_ready), 32'd1);
    step();
    idle();
    chk("nobubble a", bus.alu_a, 32'd100);
    chk("nobubble valid", 32'(bus.out_valid), 32'd1);

    drive(1'b1, 32'h00C58533, 32'h218, 32'd1, 32'd2, 1'b1, 1'b1);
    $display("txn flush+accept instr=%h", 32'h00C58533);
    #1 chk("flush in_ready", 32'(bus.in_ready), 32'd1);
    step();
    idle();
    chk("flush valid", 32'(bus.out_valid), 32'd0);

    send(32'h00B50533, 32'h21C, 32'd11, 32'd12);
    step();
    chk("consume valid", 32'(bus.out_valid), 32'd0);
    chk("consume hold a", bus.alu_a, 32'd11);

    send(32'h00B50533, 32'h220, 32'd13, 32'd14);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    $display("txn flush during stall");
    step();
    idle();
    chk("stall flush valid", 32'(bus.out_valid), 32'd0);

    send(32'h00B50533, 32'h300, 32'd15, 32'd16);
    bus.out_ready = 1'b0;
    step();
    chk("pre-rst valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    $display("txn async reset mid-stall");
    #1;
    chk("async rst valid", 32'(bus.out_valid), 32'd0);
    chk("async rst a", bus.alu_a, 32'd0);
    chk("async rst pc", bus.out_pc, TAG);
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
